// File: rtl/dual_line_monitor_pkg.sv
// Shared definitions for the dual-line monitor: FSM state encoding, the
// largest supported pipeline latency and a helper that swaps the two lines.
package dual_line_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } dlm_state_t;

  localparam int DLM_MAX_LATENCY = 7;

  // {a,b} -> {b,a}
  function automatic logic [1:0] dlm_swap(input logic [1:0] v);
    return {v[0], v[1]};
  endfunction

endpackage

// File: rtl/dlm_delay_line.sv
// dlm_delay_line: 2-bit wide, LATENCY-deep shift register with synchronous
// active-low clear. With LATENCY = 0 the input passes straight through.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low clear of every stage
//   din    {a,b} sampled this cycle
//   dout   {a,b} as sampled LATENCY cycles ago
module dlm_delay_line #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] din,
  output logic [1:0] dout
);

  generate
    if (LATENCY == 0) begin : g_pass
      logic unused_ok;
      assign unused_ok = clk ^ rst_n;
      assign dout      = din;
    end else begin : g_shift
      logic [1:0] stage [LATENCY];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY; i++) stage[i] <= 2'b00;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/dual_line_monitor.sv
// dual_line_monitor: receive-side checker for two-wire register blocks.
// Predicts the DUT outputs from the stimulus through a LATENCY-deep delay
// line (optionally swapped), compares for WINDOW cycles after a start pulse
// and reports mismatch count and pass/fail.
// Optional build macro: DLM_TRACE_EN adds first-mismatch trace outputs.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             single-cycle pulse arming a run (ignored while busy)
//   a_i, b_i          stimulus lines as driven into the DUT
//   a_o, b_o          DUT outputs under check
//   busy              high in FILL and CHECK
//   done              high in DONE until next start or reset
//   pass              valid with done; 1 when err_cnt == 0
//   err_cnt           mismatching compare cycles, saturating
//   cyc_cnt           compare cycles of the current or last run
//   first_err_cyc/obs/exp  (DLM_TRACE_EN) cyc_cnt, {a_o,b_o}, expected at
//                     the first mismatch of the run; 0 if none
//
// state  | meaning
// IDLE   | no run since reset; delay line still tracks the inputs
// FILL   | waiting LATENCY cycles for the delay line to hold run data
// CHECK  | comparing {a_o,b_o} to the prediction, one compare per cycle
// DONE   | result held; start launches a new run
module dual_line_monitor
  import dual_line_monitor_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter bit SWAP    = 1'b1,
  parameter int WINDOW  = 5,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             a_o,
  input  logic             b_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
`ifdef DLM_TRACE_EN
  output logic [CNT_W-1:0] first_err_cyc,
  output logic [1:0]       first_err_obs,
  output logic [1:0]       first_err_exp,
`endif
  output logic [CNT_W-1:0] cyc_cnt
);

  localparam logic [2:0]       FILL_INIT = 3'(LATENCY);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LAST_CYC  = CNT_W'(WINDOW - 1);

  dlm_state_t       state_q, state_d;
  logic [2:0]       fill_q, fill_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [1:0]       exp_raw, exp_ab, obs_ab;
  logic             mismatch, run_start;

  dlm_delay_line #(.LATENCY(LATENCY)) u_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({a_i, b_i}),
    .dout (exp_raw)
  );

  assign exp_ab    = SWAP ? dlm_swap(exp_raw) : exp_raw;
  assign obs_ab    = {a_o, b_o};
  assign mismatch  = (obs_ab != exp_ab);
  assign run_start = start && (state_q == ST_IDLE || state_q == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fill_q  <= 3'd0;
      err_q   <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_d   = '0;
          cyc_d   = '0;
          fill_d  = FILL_INIT;
          state_d = (FILL_INIT == 3'd0) ? ST_CHECK : ST_FILL;
        end
      end
      ST_FILL: begin
        fill_d = fill_q - 3'd1;
        if (fill_q <= 3'd1) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (mismatch && err_q != CNT_MAX) err_d = err_q + 1'b1;
        if (cyc_q != CNT_MAX) cyc_d = cyc_q + 1'b1;
        // Old count equal to WINDOW-1 means this is the WINDOW-th compare.
        if (cyc_q == LAST_CYC) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy    = (state_q == ST_FILL) || (state_q == ST_CHECK);
  assign done    = (state_q == ST_DONE);
  assign pass    = done && (err_q == '0);
  assign err_cnt = err_q;
  assign cyc_cnt = cyc_q;

`ifdef DLM_TRACE_EN
  logic [CNT_W-1:0] fe_cyc_q;
  logic [1:0]       fe_obs_q, fe_exp_q;

  // err_q still zero in CHECK identifies the first mismatch of the run.
  always_ff @(posedge clk) begin
    if (!rst_n || run_start) begin
      fe_cyc_q <= '0;
      fe_obs_q <= 2'b00;
      fe_exp_q <= 2'b00;
    end else if (state_q == ST_CHECK && mismatch && err_q == '0) begin
      fe_cyc_q <= cyc_q;
      fe_obs_q <= obs_ab;
      fe_exp_q <= exp_ab;
    end
  end

  assign first_err_cyc = fe_cyc_q;
  assign first_err_obs = fe_obs_q;
  assign first_err_exp = fe_exp_q;
`else
  logic unused_run_start;
  assign unused_run_start = run_start;
`endif

endmodule
